proc_run_monitor: RTL and testbench
===================================

Name: proc_run_monitor

Overview:
- Synthesizable run controller and self-checker for the pipelined processor; generalised successor of the bench-side run/watchdog/pass-count harness.
- Sequences processor reset with a programmable start PC, then runs until the PC reaches a programmable end PC or a watchdog expires.
- Checks write-back results against an ordered table of NUM_CHECKS expected (pc, data) pairs and reports pass/fail counts.
- Sits beside the `processor` top: drives its resetl/startpc and observes currentpc plus the write-back bus.

Parameters:
- PC_WIDTH, 64, width of all PC values
- DATA_WIDTH, 64, width of write-back data
- NUM_CHECKS, 4, depth of the expected-result table (>=1)
- WDOG_WIDTH, 16, watchdog counter width
- WDOG_LIMIT, 255, cycle count in RUN at which the run is killed
- RESET_CYCLES, 1, cycles proc_resetl is held low (>=1)
- SETTLE_CYCLES, 1, extra cycles after end PC before checking completes (>=0)

Ports:
- CLK  in  1  clock; all logic on rising edge
- Reset  in  1  synchronous, active-high reset
- start  in  1  pulse; begins a run (ignored unless IDLE or DONE)
- start_pc  in  PC_WIDTH  PC forwarded to processor startpc
- end_pc  in  PC_WIDTH  run terminates when currentpc >= end_pc
- exp_we  in  1  write expected-table entry (IDLE/DONE only)
- exp_idx  in  clog2(NUM_CHECKS)  table index
- exp_pc  in  PC_WIDTH  PC whose write-back is checked
- exp_data  in  DATA_WIDTH  expected write-back value
- num_checks  in  clog2(NUM_CHECKS)+1  active entries for this run (0..NUM_CHECKS)
- currentpc  in  PC_WIDTH  processor current PC
- wb_valid  in  1  write-back occurring this cycle
- wb_pc  in  PC_WIDTH  PC of the write-back instruction
- wb_data  in  DATA_WIDTH  write-back value
- proc_resetl  out  1  active-low reset to processor
- proc_startpc  out  PC_WIDTH  registered copy of start_pc
- busy  out  1  high in RST, RUN, SETTLE
- done  out  1  high in DONE
- timeout  out  1  watchdog expired on the last run
- pass_count  out  8  checks passed
- fail_count  out  8  checks failed or missed
- all_passed  out  1  done & !timeout & pass_count==num_checks
- cycle_count  out  WDOG_WIDTH  RUN cycles of the last run

Behaviour:
- Reset: state IDLE; proc_resetl=1; proc_startpc=0; busy/done/timeout=0; counts=0; table contents undefined (not cleared).
- IDLE/DONE + start: latch start_pc to proc_startpc and end_pc internally; clear counts, timeout, cycle_count, check pointer; go to RST.
- RST: proc_resetl=0 for exactly RESET_CYCLES cycles, then RUN with proc_resetl=1.
- RUN: cycle_count += 1 each cycle.
  - If currentpc >= end_pc (unsigned): go to SETTLE, or directly to CHECK_END when SETTLE_CYCLES=0.
  - Else if cycle_count+1 == WDOG_LIMIT: timeout=1, go to DONE.
  - End-PC test has priority over watchdog in the same cycle.
- Checking (RUN and SETTLE): pointer p < num_checks; on wb_valid & wb_pc==table[p].pc:
  - wb_data==table[p].data -> pass_count+1, else fail_count+1; p+1.
  - One check per cycle at most.
  - Writes at other PCs are ignored.
- SETTLE: runs SETTLE_CYCLES cycles with checking still active, then CHECK_END.
- CHECK_END (1 cycle): fail_count += num_checks - p (missed entries), go to DONE.
- Timeout path skips CHECK_END; missed entries are not counted.
- DONE: done=1; outputs hold until next start.
- Counts saturate at 255.
- exp_we while busy is ignored; exp_we with exp_idx >= NUM_CHECKS is ignored.
- num_checks is sampled at start; values > NUM_CHECKS are clamped.
- Reset mid-run: returns to IDLE immediately, proc_resetl=1 the next cycle.
- start while busy: ignored.

Optional Feature:
- MON_FAIL_CAPTURE_EN defined: adds outputs first_fail_idx (clog2(NUM_CHECKS)), first_fail_data (DATA_WIDTH), first_fail_valid (1).
  - Capture the index and wb_data of the first data mismatch in a run.
  - Cleared by Reset and start.
  - Missed entries do not set first_fail_valid.
- Undefined: these ports and registers are absent; all other behaviour is identical.

Test Plan:
- Load 1 entry (pc=0x30, data=12), start_pc=0, end_pc=0x34; drive wb_valid at pc 0x30 data 12, then currentpc=0x34.
  - proc_resetl low exactly 1 cycle; pass_count=1, fail_count=0, all_passed=1, done=1.
- Same setup, wb_data=13.
  - fail_count=1, all_passed=0; with MON_FAIL_CAPTURE_EN: first_fail_idx=0, first_fail_data=13.
- currentpc held at 0x10, WDOG_LIMIT=255.
  - timeout=1 and done after 255 RUN cycles, cycle_count=255.
- num_checks=3, only entry 0 written back before end PC.
  - pass_count=1, fail_count=2 after CHECK_END.
- Reset asserted during RUN.
  - Next cycle: IDLE, busy=0, proc_resetl=1; a new start runs cleanly with counts restarted from 0.
- start pulsed while busy, and exp_we during RUN.
  - No state change; table entry unchanged.

Source files
------------

// File: rtl/proc_run_monitor.sv
// proc_run_monitor: sequences processor reset, runs to an end PC or watchdog, and checks write-backs
// against an ordered expected table. Define MON_FAIL_CAPTURE_EN to add first-mismatch capture ports.
module proc_run_monitor #(
    parameter int PC_WIDTH      = 64,
    parameter int DATA_WIDTH    = 64,
    parameter int NUM_CHECKS    = 4,
    parameter int WDOG_WIDTH    = 16,
    parameter int WDOG_LIMIT    = 255,
    parameter int RESET_CYCLES  = 1,
    parameter int SETTLE_CYCLES = 1,
    localparam int IDX_W = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1,
    localparam int NC_W  = $clog2(NUM_CHECKS) + 1
) (
    input  logic                  CLK,
    input  logic                  Reset,
    input  logic                  start,
    input  logic [PC_WIDTH-1:0]   start_pc,
    input  logic [PC_WIDTH-1:0]   end_pc,
    input  logic                  exp_we,
    input  logic [IDX_W-1:0]      exp_idx,
    input  logic [PC_WIDTH-1:0]   exp_pc,
    input  logic [DATA_WIDTH-1:0] exp_data,
    input  logic [NC_W-1:0]       num_checks,
    input  logic [PC_WIDTH-1:0]   currentpc,
    input  logic                  wb_valid,
    input  logic [PC_WIDTH-1:0]   wb_pc,
    input  logic [DATA_WIDTH-1:0] wb_data,
    output logic                  proc_resetl,
    output logic [PC_WIDTH-1:0]   proc_startpc,
    output logic                  busy,
    output logic                  done,
    output logic                  timeout,
    output logic [7:0]            pass_count,
    output logic [7:0]            fail_count,
    output logic                  all_passed,
    output logic [WDOG_WIDTH-1:0] cycle_count,
`ifdef MON_FAIL_CAPTURE_EN
    output logic [IDX_W-1:0]      first_fail_idx,
    output logic [DATA_WIDTH-1:0] first_fail_data,
    output logic                  first_fail_valid,
`endif
    output logic [2:0]            state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_RST       = 3'd1,
        S_RUN       = 3'd2,
        S_SETTLE    = 3'd3,
        S_CHECK_END = 3'd4,
        S_DONE      = 3'd5
    } state_t;

    localparam int RST_W = $clog2(RESET_CYCLES + 1);
    localparam int SET_W = $clog2(SETTLE_CYCLES + 2);

    state_t                state;
    logic [RST_W-1:0]      rst_cnt;
    logic [SET_W-1:0]      settle_cnt;
    logic [PC_WIDTH-1:0]   end_pc_r;
    logic [NC_W-1:0]       nc_r;
    logic [NC_W-1:0]       ptr;
    logic [PC_WIDTH-1:0]   tbl_pc   [NUM_CHECKS];
    logic [DATA_WIDTH-1:0] tbl_data [NUM_CHECKS];

    logic             idle_or_done;
    logic             checking;
    logic             hit;
    logic             match;
    logic [IDX_W-1:0] ptr_idx;
    logic [NC_W-1:0]  nc_clamped;
    logic [8:0]       missed_sum;

    // start and exp_we are single-cycle strobes, acted on only in IDLE/DONE; wb_valid qualifies
    // wb_pc/wb_data in the same cycle and has no back-pressure.
    assign idle_or_done = (state == S_IDLE) || (state == S_DONE);
    assign checking     = (state == S_RUN) || (state == S_SETTLE);
    assign ptr_idx      = ptr[IDX_W-1:0];
    assign hit          = checking && wb_valid && (ptr < nc_r) && (wb_pc == tbl_pc[ptr_idx]);
    assign match        = (wb_data == tbl_data[ptr_idx]);
    assign nc_clamped   = (32'(num_checks) > NUM_CHECKS) ? NC_W'(NUM_CHECKS) : num_checks;
    assign missed_sum   = {1'b0, fail_count} + 9'(nc_r - ptr);

    assign proc_resetl = (state != S_RST);
    assign busy        = (state == S_RST) || (state == S_RUN) || (state == S_SETTLE);
    assign done        = (state == S_DONE);
    assign all_passed  = done && !timeout && (pass_count == 8'(nc_r));
    assign state_dbg   = state;

    // Table is deliberately not reset; it is only rewritten between runs.
    always_ff @(posedge CLK) begin
        if (exp_we && idle_or_done && (32'(exp_idx) < NUM_CHECKS)) begin
            tbl_pc[exp_idx]   <= exp_pc;
            tbl_data[exp_idx] <= exp_data;
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state        <= S_IDLE;
            rst_cnt      <= '0;
            settle_cnt   <= '0;
            end_pc_r     <= '0;
            nc_r         <= '0;
            ptr          <= '0;
            proc_startpc <= '0;
            timeout      <= 1'b0;
            pass_count   <= '0;
            fail_count   <= '0;
            cycle_count  <= '0;
        end else begin
            if (hit) begin
                if (match) begin
                    if (pass_count != 8'hFF) pass_count <= pass_count + 8'd1;
                end else begin
                    if (fail_count != 8'hFF) fail_count <= fail_count + 8'd1;
                end
                ptr <= ptr + NC_W'(1);
            end
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        proc_startpc <= start_pc;
                        end_pc_r     <= end_pc;
                        nc_r         <= nc_clamped;
                        ptr          <= '0;
                        pass_count   <= '0;
                        fail_count   <= '0;
                        timeout      <= 1'b0;
                        cycle_count  <= '0;
                        rst_cnt      <= RST_W'(RESET_CYCLES);
                        state        <= S_RST;
                    end
                end
                S_RST: begin
                    if (rst_cnt == RST_W'(1)) state <= S_RUN;
                    else rst_cnt <= rst_cnt - RST_W'(1);
                end
                S_RUN: begin
                    cycle_count <= cycle_count + WDOG_WIDTH'(1);
                    // End PC wins over the watchdog when both fire in one cycle.
                    if (currentpc >= end_pc_r) begin
                        if (SETTLE_CYCLES == 0) begin
                            state <= S_CHECK_END;
                        end else begin
                            settle_cnt <= SET_W'(SETTLE_CYCLES);
                            state      <= S_SETTLE;
                        end
                    end else if (cycle_count + WDOG_WIDTH'(1) == WDOG_WIDTH'(WDOG_LIMIT)) begin
                        timeout <= 1'b1;
                        state   <= S_DONE;
                    end
                end
                S_SETTLE: begin
                    if (settle_cnt == SET_W'(1)) state <= S_CHECK_END;
                    else settle_cnt <= settle_cnt - SET_W'(1);
                end
                S_CHECK_END: begin
                    fail_count <= missed_sum[8] ? 8'hFF : missed_sum[7:0];
                    state      <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef MON_FAIL_CAPTURE_EN
    always_ff @(posedge CLK) begin
        if (Reset || (idle_or_done && start)) begin
            first_fail_idx   <= '0;
            first_fail_data  <= '0;
            first_fail_valid <= 1'b0;
        end else if (hit && !match && !first_fail_valid) begin
            first_fail_idx   <= ptr_idx;
            first_fail_data  <= wb_data;
            first_fail_valid <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_proc_run_monitor.sv
// Bench for proc_run_monitor: directed and random runs, reference model feeding a scoreboard queue.
module tb_proc_run_monitor;
    localparam int NC            = 4;
    localparam int WDOG_LIMIT    = 255;
    localparam int RESET_CYCLES  = 1;
    localparam int SETTLE_CYCLES = 1;
    localparam int MAXC          = 300;
    localparam int EXP_W         = 34;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        start;
    logic [63:0] start_pc, end_pc;
    logic        exp_we;
    logic [1:0]  exp_idx;
    logic [63:0] exp_pc, exp_data;
    logic [2:0]  num_checks;
    logic [63:0] currentpc;
    logic        wb_valid;
    logic [63:0] wb_pc, wb_data;
    logic        proc_resetl;
    logic [63:0] proc_startpc;
    logic        busy, done, timeout, all_passed;
    logic [7:0]  pass_count, fail_count;
    logic [15:0] cycle_count;
    logic [2:0]  state_dbg;
`ifdef MON_FAIL_CAPTURE_EN
    logic [1:0]  first_fail_idx;
    logic [63:0] first_fail_data;
    logic        first_fail_valid;
`endif

    proc_run_monitor dut (
        .CLK(CLK), .Reset(Reset), .start(start), .start_pc(start_pc), .end_pc(end_pc),
        .exp_we(exp_we), .exp_idx(exp_idx), .exp_pc(exp_pc), .exp_data(exp_data),
        .num_checks(num_checks), .currentpc(currentpc), .wb_valid(wb_valid),
        .wb_pc(wb_pc), .wb_data(wb_data), .proc_resetl(proc_resetl),
        .proc_startpc(proc_startpc), .busy(busy), .done(done), .timeout(timeout),
        .pass_count(pass_count), .fail_count(fail_count), .all_passed(all_passed),
        .cycle_count(cycle_count),
`ifdef MON_FAIL_CAPTURE_EN
        .first_fail_idx(first_fail_idx), .first_fail_data(first_fail_data),
        .first_fail_valid(first_fail_valid),
`endif
        .state_dbg(state_dbg)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    logic [EXP_W-1:0] exp_q[$];

    logic [63:0] tbl_pc [NC];
    logic [63:0] tbl_data [NC];
    logic [63:0] cur_pc_a [MAXC];
    logic        v_a [MAXC];
    logic [63:0] wpc_a [MAXC];
    logic [63:0] wdata_a [MAXC];
    logic [63:0] run_start_pc, run_end_pc;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: scan for the end/watchdog cycle, then walk write-backs in order against the table.
    function automatic logic [EXP_W-1:0] model(input int nc_in);
        int nc, p, pass_n, fail_n, last, cc;
        bit to;
        nc = (nc_in > NC) ? NC : nc_in;
        p = 0; pass_n = 0; fail_n = 0; last = -1; cc = 0; to = 0;
        for (int k = 0; k < MAXC; k++) begin
            if (cur_pc_a[k] >= run_end_pc) begin
                last = k + SETTLE_CYCLES; cc = k + 1; break;
            end
            if (k + 1 == WDOG_LIMIT) begin
                to = 1; last = k; cc = k + 1; break;
            end
        end
        for (int k = 0; k <= last; k++) begin
            if (v_a[k] && p < nc && wpc_a[k] == tbl_pc[p]) begin
                if (wdata_a[k] == tbl_data[p]) pass_n++;
                else fail_n++;
                p++;
            end
        end
        if (!to) fail_n += nc - p;
        if (pass_n > 255) pass_n = 255;
        if (fail_n > 255) fail_n = 255;
        return {to, (!to && pass_n == nc), 8'(pass_n), 8'(fail_n), 16'(cc)};
    endfunction

    logic done_q = 1'b0;
    always @(negedge CLK) begin
        logic [EXP_W-1:0] e;
        if (done && !done_q) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_done: got done=1 expected no pending run");
            end else begin
                e = exp_q.pop_front();
                check("timeout", timeout, e[33]);
                check("all_passed", all_passed, e[32]);
                check("pass_count", pass_count, e[31:24]);
                check("fail_count", fail_count, e[23:16]);
                check("cycle_count", cycle_count, e[15:0]);
            end
        end
        done_q <= done;
    end

    task automatic load_entry(input int i, input logic [63:0] pc, input logic [63:0] d);
        @(negedge CLK);
        exp_we = 1'b1; exp_idx = i[1:0]; exp_pc = pc; exp_data = d;
        @(negedge CLK);
        exp_we = 1'b0;
        tbl_pc[i] = pc; tbl_data[i] = d;
    endtask

    task automatic clear_arrays(input logic [63:0] pc);
        for (int k = 0; k < MAXC; k++) begin
            cur_pc_a[k] = pc; v_a[k] = 1'b0; wpc_a[k] = '0; wdata_a[k] = '0;
        end
    endtask

    task automatic drive_cycle(input int k, input bit disturb);
        currentpc  = cur_pc_a[k];
        wb_valid   = v_a[k];
        wb_pc      = wpc_a[k];
        wb_data    = wdata_a[k];
        num_checks = 3'($urandom_range(0, 7));
        end_pc     = {$urandom, $urandom};
        start      = disturb && (k == 1);
        exp_we     = disturb && (k == 1);
        start_pc   = ~run_start_pc;
        exp_idx    = 2'd0;
        exp_pc     = '1;
        exp_data   = '1;
    endtask

    task automatic start_run(input logic [2:0] nc_in, output int lowc);
        @(negedge CLK);
        start_pc = run_start_pc; end_pc = run_end_pc; num_checks = nc_in;
        start = 1'b1; wb_valid = 1'b0;
        @(negedge CLK);
        start = 1'b0;
        lowc = 0;
        while (!proc_resetl && lowc < 20) begin
            lowc++;
            @(negedge CLK);
        end
    endtask

    task automatic do_run(input logic [2:0] nc_in, input bit disturb);
        int lowc, k;
        exp_q.push_back(model(int'(nc_in)));
        start_run(nc_in, lowc);
        check("reset_pulse_len", 64'(lowc), 64'(RESET_CYCLES));
        k = 0;
        while (!done && k < MAXC) begin
            drive_cycle(k, disturb);
            @(negedge CLK);
            k++;
        end
        start = 1'b0; exp_we = 1'b0; wb_valid = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL run_done: got done=0 after %0d cycles expected done", k);
        end
        check("proc_startpc", proc_startpc, run_start_pc);
    endtask

    task automatic random_run(input bit reload);
        int e_cyc;
        bit to_run;
        logic [2:0] nc_in;
        if (reload)
            for (int i = 0; i < NC; i++)
                load_entry(i, 64'h100 + 64'(4 * $urandom_range(0, 7)), {$urandom, $urandom});
        run_start_pc = {$urandom, $urandom};
        run_end_pc   = 64'h1000 + 64'(4 * $urandom_range(0, 255));
        to_run = ($urandom_range(0, 5) == 0);
        e_cyc  = $urandom_range(0, 40);
        nc_in  = 3'($urandom_range(0, 7));
        for (int k = 0; k < MAXC; k++) begin
            int j;
            j = $urandom_range(0, NC - 1);
            if (to_run || k < e_cyc) cur_pc_a[k] = run_end_pc - 64'(1 + $urandom_range(0, 63));
            else cur_pc_a[k] = run_end_pc + 64'($urandom_range(0, 3));
            v_a[k]     = $urandom_range(0, 1) == 1;
            wpc_a[k]   = ($urandom_range(0, 3) == 0) ? 64'h200 + 64'($urandom_range(0, 7)) : tbl_pc[j];
            wdata_a[k] = ($urandom_range(0, 3) == 0) ? tbl_data[j] ^ 64'h1 : tbl_data[j];
        end
        do_run(nc_in, 1'b0);
    endtask

    task automatic setup_basic(input logic [63:0] data);
        clear_arrays(64'h34);
        cur_pc_a[0] = 64'h30; v_a[0] = 1'b1; wpc_a[0] = 64'h30; wdata_a[0] = data;
        run_start_pc = 64'h0; run_end_pc = 64'h34;
    endtask

    initial begin
        int lowc;
        Reset = 1'b1; start = 1'b0; start_pc = '0; end_pc = '0; exp_we = 1'b0;
        exp_idx = '0; exp_pc = '0; exp_data = '0; num_checks = '0; currentpc = '0;
        wb_valid = 1'b0; wb_pc = '0; wb_data = '0;
        run_start_pc = '0; run_end_pc = '0;
        repeat (3) @(negedge CLK);
        check("rst_proc_resetl", proc_resetl, 1);
        check("rst_proc_startpc", proc_startpc, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_timeout", timeout, 0);
        check("rst_pass", pass_count, 0);
        check("rst_fail", fail_count, 0);
        check("rst_cycle_count", cycle_count, 0);
        check("rst_all_passed", all_passed, 0);
        Reset = 1'b0;

        load_entry(0, 64'h30, 64'd12);
        setup_basic(64'd12);
        do_run(3'd1, 1'b0);

        setup_basic(64'd13);
        do_run(3'd1, 1'b0);
`ifdef MON_FAIL_CAPTURE_EN
        check("first_fail_valid", first_fail_valid, 1);
        check("first_fail_idx", first_fail_idx, 0);
        check("first_fail_data", first_fail_data, 13);
`endif

        clear_arrays(64'h10);
        run_end_pc = 64'h34;
        do_run(3'd1, 1'b0);

        load_entry(1, 64'h38, 64'd22);
        load_entry(2, 64'h40, 64'd32);
        clear_arrays(64'h50);
        cur_pc_a[0] = 64'h2C; cur_pc_a[1] = 64'h2C;
        v_a[0] = 1'b1; wpc_a[0] = 64'h30; wdata_a[0] = 64'd12;
        run_end_pc = 64'h50;
        do_run(3'd3, 1'b0);

        clear_arrays(64'h34);
        for (int k = 0; k < 5; k++) cur_pc_a[k] = 64'h20;
        v_a[3] = 1'b1; wpc_a[3] = 64'h30; wdata_a[3] = 64'd12;
        run_start_pc = 64'h1234;
        do_run(3'd1, 1'b1);

        setup_basic(64'd12);
        start_run(3'd1, lowc);
        currentpc = 64'h0; wb_valid = 1'b1; wb_pc = 64'h30; wb_data = 64'd12;
        @(negedge CLK);
        wb_valid = 1'b0;
        @(negedge CLK);
        check("pass_before_reset", pass_count, 1);
        Reset = 1'b1;
        @(negedge CLK);
        Reset = 1'b0;
        check("midrst_busy", busy, 0);
        check("midrst_proc_resetl", proc_resetl, 1);
        check("midrst_done", done, 0);
        check("midrst_pass", pass_count, 0);
        do_run(3'd1, 1'b0);

        for (int r = 0; r < 20; r++) random_run(r % 4 == 0);

        repeat (3) @(negedge CLK);
        check("scoreboard_empty", 64'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
